// File: rtl/y86_regfile_param.sv
// Y86 register file: two combinational read ports and two synchronous write ports (E, M).
// M wins on same-ID collisions. It has optional write-through bypass, a stall freeze and a saturating write counter.
module y86_regfile_param #(
  parameter int                DATA_W   = 64,
  parameter int                ID_W     = 4,
  parameter int                NREGS    = 15,
  parameter int                RSP_ID   = 4,
  parameter logic [DATA_W-1:0] RSP_INIT = 64'h0000_0000_0000_0200,
  parameter int                BYPASS   = 1,
  parameter int                CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic [ID_W-1:0]   srcA,
  input  logic [ID_W-1:0]   srcB,
  output logic [DATA_W-1:0] valA,
  output logic [DATA_W-1:0] valB,
  input  logic [ID_W-1:0]   dstE,
  input  logic [DATA_W-1:0] valE,
  input  logic [ID_W-1:0]   dstM,
  input  logic [DATA_W-1:0] valM,
  output logic [CNT_W-1:0]  wr_cnt
);

  localparam logic [ID_W-1:0]  NREGS_ID = ID_W'(NREGS);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic [DATA_W-1:0] regs [NREGS];
  logic              e_valid;
  logic              m_valid;
  logic              e_wr;
  logic              fwd_en;

  assign e_valid = !stall && (dstE < NREGS_ID);
  assign m_valid = !stall && (dstM < NREGS_ID);
  // On a collision the E write is dropped so M lands, as popq %rsp requires.
  assign e_wr    = e_valid && !(m_valid && (dstM == dstE));
  // Forwarding is off while reset is asserted, so reads show the reset contents.
  assign fwd_en  = (BYPASS != 0) && rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= (i == RSP_ID) ? RSP_INIT : '0;
      end
    end else begin
      if (e_wr)    regs[dstE] <= valE;
      if (m_valid) regs[dstM] <= valM;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt <= '0;
    end else if ((e_valid || m_valid) && (wr_cnt != CNT_MAX)) begin
      wr_cnt <= wr_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    valA = '0;
    if (srcA < NREGS_ID) begin
      if (fwd_en && m_valid && (srcA == dstM))      valA = valM;
      else if (fwd_en && e_valid && (srcA == dstE)) valA = valE;
      else                                          valA = regs[srcA];
    end
  end

  always_comb begin
    valB = '0;
    if (srcB < NREGS_ID) begin
      if (fwd_en && m_valid && (srcB == dstM))      valB = valM;
      else if (fwd_en && e_valid && (srcB == dstE)) valB = valE;
      else                                          valB = regs[srcB];
    end
  end

endmodule

// File: tb/tb_y86_regfile_param.sv
// Bench for y86_regfile_param: a bypass instance and a no-bypass instance with a 2-bit counter, driven in parallel.
module tb_y86_regfile_param;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic [3:0]  srcA, srcB, dstE, dstM;
  logic [63:0] valE, valM;
  logic [63:0] valA_b, valB_b, valA_n, valB_n;
  logic [15:0] cnt_b;
  logic [1:0]  cnt_n;

  always #5 clk = ~clk;

  y86_regfile_param #(.BYPASS(1), .CNT_W(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .stall(stall), .srcA(srcA), .srcB(srcB),
    .valA(valA_b), .valB(valB_b), .dstE(dstE), .valE(valE),
    .dstM(dstM), .valM(valM), .wr_cnt(cnt_b));

  y86_regfile_param #(.BYPASS(0), .CNT_W(2)) dut_n (
    .clk(clk), .rst_n(rst_n), .stall(stall), .srcA(srcA), .srcB(srcB),
    .valA(valA_n), .valB(valB_n), .dstE(dstE), .valE(valE),
    .dstM(dstM), .valM(valM), .wr_cnt(cnt_n));

  typedef struct {
    logic        stall;
    logic [3:0]  srcA, srcB, dstE;
    logic [63:0] valE;
    logic [3:0]  dstM;
    logic [63:0] valM;
    logic        has_exp;
    logic [63:0] exp_a, exp_b;
  } vec_t;

  typedef struct {
    logic [63:0] a_b, b_b, a_n, b_n;
    logic [15:0] c_b;
    logic [1:0]  c_n;
  } exp_t;

  vec_t        tbl[12];
  exp_t        sbq[$];
  logic [63:0] mregs[15];
  logic [15:0] mcnt_b;
  logic [1:0]  mcnt_n;
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 15; i++) mregs[i] = '0;
    mregs[4] = 64'h200;
    mcnt_b   = '0;
    mcnt_n   = '0;
  endtask

  function automatic logic [63:0] model_read(input logic [3:0] id, input logic byp);
    logic ev, mv;
    ev = !stall && (dstE < 4'd15);
    mv = !stall && (dstM < 4'd15);
    if (id >= 4'd15) return '0;
    if (byp && mv && id == dstM) return valM;
    if (byp && ev && id == dstE) return valE;
    return mregs[id];
  endfunction

  task automatic model_edge();
    logic ev, mv;
    ev = !stall && (dstE < 4'd15);
    mv = !stall && (dstM < 4'd15);
    if (ev && !(mv && dstM == dstE)) mregs[dstE] = valE;
    if (mv) mregs[dstM] = valM;
    if (ev || mv) begin
      if (mcnt_b != 16'hFFFF) mcnt_b = mcnt_b + 16'd1;
      if (mcnt_n != 2'd3)     mcnt_n = mcnt_n + 2'd1;
    end
  endtask

  // Drive one cycle of stimulus, queue the model's view, compare mid-cycle, then advance the model at the edge.
  task automatic apply(input vec_t v, input string tag);
    exp_t e, g;
    stall = v.stall; srcA = v.srcA; srcB = v.srcB;
    dstE = v.dstE; valE = v.valE; dstM = v.dstM; valM = v.valM;
    #1;
    e.a_b = model_read(srcA, 1'b1);
    e.b_b = model_read(srcB, 1'b1);
    e.a_n = model_read(srcA, 1'b0);
    e.b_n = model_read(srcB, 1'b0);
    e.c_b = mcnt_b;
    e.c_n = mcnt_n;
    sbq.push_back(e);
    @(negedge clk);
    g = sbq.pop_front();
    chk({tag, " valA_byp"}, valA_b, g.a_b);
    chk({tag, " valB_byp"}, valB_b, g.b_b);
    chk({tag, " valA_nobyp"}, valA_n, g.a_n);
    chk({tag, " valB_nobyp"}, valB_n, g.b_n);
    chk({tag, " wr_cnt16"}, 64'(cnt_b), 64'(g.c_b));
    chk({tag, " wr_cnt2"}, 64'(cnt_n), 64'(g.c_n));
    if (v.has_exp) begin
      chk({tag, " tbl valA"}, valA_b, v.exp_a);
      chk({tag, " tbl valB"}, valB_b, v.exp_b);
    end
    @(posedge clk);
    model_edge();
    #1;
  endtask

  function automatic vec_t mk(input logic st, input logic [3:0] sa, input logic [3:0] sb,
                              input logic [3:0] de, input logic [63:0] ve,
                              input logic [3:0] dm, input logic [63:0] vm,
                              input logic he, input logic [63:0] ea, input logic [63:0] eb);
    vec_t v;
    v.stall = st; v.srcA = sa; v.srcB = sb; v.dstE = de; v.valE = ve;
    v.dstM = dm; v.valM = vm; v.has_exp = he; v.exp_a = ea; v.exp_b = eb;
    return v;
  endfunction

  initial begin
    // Expected values are the bypass instance's reads before the edge.
    tbl[0]  = mk(0, 4'd4,  4'd0, 4'hF, 64'h0,           4'hF,  64'h0,  1, 64'h200,         64'h0);
    tbl[1]  = mk(0, 4'hF,  4'd4, 4'hF, 64'h0,           4'hF,  64'h0,  1, 64'h0,           64'h200);
    tbl[2]  = mk(0, 4'd2,  4'd2, 4'd2, 64'h34_2486_7AEC, 4'hF, 64'h0,  1, 64'h34_2486_7AEC, 64'h34_2486_7AEC);
    tbl[3]  = mk(0, 4'd2,  4'd7, 4'd7, 64'h6567,        4'hF,  64'h0,  1, 64'h34_2486_7AEC, 64'h6567);
    tbl[4]  = mk(0, 4'd4,  4'd7, 4'd4, 64'h1F8,         4'd4,  64'hABCD, 1, 64'hABCD,      64'h6567);
    tbl[5]  = mk(1, 4'd3,  4'd4, 4'd3, 64'h55,          4'hF,  64'h0,  1, 64'h0,           64'hABCD);
    tbl[6]  = mk(1, 4'd3,  4'd4, 4'd3, 64'h55,          4'hF,  64'h0,  1, 64'h0,           64'hABCD);
    tbl[7]  = mk(1, 4'd3,  4'd4, 4'd3, 64'h55,          4'hF,  64'h0,  1, 64'h0,           64'hABCD);
    tbl[8]  = mk(0, 4'd14, 4'd3, 4'hF, 64'h0,           4'd14, 64'hEE, 1, 64'hEE,          64'h0);
    tbl[9]  = mk(0, 4'd14, 4'd2, 4'hF, 64'h123,         4'hF,  64'h456, 1, 64'hEE,         64'h34_2486_7AEC);
    tbl[10] = mk(0, 4'd1,  4'd2, 4'd1, 64'h11,          4'd2,  64'h22, 1, 64'h11,          64'h22);
    tbl[11] = mk(0, 4'd1,  4'd2, 4'hF, 64'h0,           4'hF,  64'h0,  1, 64'h11,          64'h22);

    rst_n = 1'b0; stall = 1'b0; srcA = 4'd4; srcB = 4'd0;
    dstE = 4'hF; valE = '0; dstM = 4'hF; valM = '0;
    model_reset();
    #12;
    chk("reset valA rsp", valA_b, 64'h200);
    chk("reset valB r0", valB_b, 64'h0);
    chk("reset wr_cnt", 64'(cnt_b), 64'h0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) apply(tbl[i], $sformatf("vec%0d", i));
    chk("stored r3 after stall", 64'(mregs[3]), 64'h0);
    chk("stored r4 after collision", 64'(mregs[4]), 64'hABCD);

    // Async reset between edges, with a write presented while reset is held.
    apply(mk(0, 4'd2, 4'd4, 4'd2, 64'h99, 4'hF, 64'h0, 0, 0, 0), "pre_rst");
    dstE = 4'd2; valE = 64'h77; srcA = 4'd2; srcB = 4'd4;
    #2 rst_n = 1'b0;
    #1 model_reset();
    chk("async rst valA_byp", valA_b, 64'h0);
    chk("async rst valB_byp", valB_b, 64'h200);
    chk("async rst valA_nobyp", valA_n, 64'h0);
    chk("async rst wr_cnt2", 64'(cnt_n), 64'h0);
    @(posedge clk); #1;
    chk("write in rst valA_byp", valA_b, 64'h0);
    chk("write in rst valA_nobyp", valA_n, 64'h0);
    @(negedge clk);
    dstE = 4'hF;
    rst_n = 1'b1;
    @(posedge clk); #1;
    apply(mk(0, 4'd2, 4'd4, 4'hF, 64'h0, 4'hF, 64'h0, 1, 64'h0, 64'h200), "post_rst");

    // Reset asserted on the same edge as a pending write.
    stall = 1'b0; srcA = 4'd5; srcB = 4'd4; dstE = 4'd5; valE = 64'h5555; dstM = 4'hF;
    @(posedge clk) rst_n = 1'b0;
    #1 model_reset();
    chk("edge rst valA_nobyp", valA_n, 64'h0);
    chk("edge rst wr_cnt16", 64'(cnt_b), 64'h0);
    @(negedge clk);
    dstE = 4'hF;
    rst_n = 1'b1;
    @(posedge clk); #1;
    apply(mk(0, 4'd5, 4'd4, 4'hF, 64'h0, 4'hF, 64'h0, 1, 64'h0, 64'h200), "edge_post");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
